n2_btb: RTL and testbench
=========================

Name: n2_btb

Overview:
- Branch target buffer and branch history table. It is the receiving end of the execute unit's BTB-update interface and the producing end of the `btb_ctl_t` prediction bundle that the execute unit consumes.
- Fetch presents a PC and gets a registered prediction one cycle later: hit, jump, target, entry ID.
- Execute drives insert, BHT-train and target-update requests.
- Fully associative table; 2-bit saturating counter per entry.

Parameters:
- ENTRIES, 8, number of BTB entries (power of two, 2..32)
- ENTRY_W, $clog2(ENTRIES), entry ID width
- BHT_INIT, 2'b10, counter value written on insert (weakly taken)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- flush_i  in  1  invalidate all entries
- lookup_v_i  in  1  lookup request valid
- lookup_pc_i  in  32  fetch PC to look up
- pred_v_o  out  1  prediction valid (lookup_v_i delayed one cycle)
- pred_hit_o  out  1  lookup PC matched a valid entry
- pred_jump_o  out  1  hit and counter[1]==1
- pred_tgt_o  out  32  stored target of the matching entry
- pred_pc_o  out  32  registered lookup PC
- pred_entry_o  out  ENTRY_W  index of the matching entry
- upd_v_i  in  1  update request valid
- upd_insert_i  in  1  allocate entry for upd_pc_i
- upd_bht_i  in  1  train counter of upd_entry_i
- upd_inc_i  in  1  1 = increment counter, 0 = decrement
- upd_tgt_en_i  in  1  overwrite target of upd_entry_i
- upd_pc_i  in  32  branch PC (used by insert)
- upd_tgt_i  in  32  branch target
- upd_entry_i  in  ENTRY_W  entry returned by the earlier prediction

Behaviour:
- Per-entry state: valid, tag = pc[31:1], tgt[31:0], cnt[1:0].
- Reset (rst=1 at posedge):
  - valid cleared, cnt=00, replacement pointer=0.
  - pred_v_o, pred_hit_o, pred_jump_o = 0.
  - pred_tgt_o, pred_pc_o, pred_entry_o = 0.
  - Reset has priority over all requests; a request present during reset is dropped.
- Lookup, latency 1:
  - Combinational tag compare over all entries at cycle T; results registered at posedge T+1.
  - pred_jump_o = hit & cnt[1].
  - On a miss: pred_tgt_o=0, pred_entry_o=0.
  - When lookup_v_i=0: pred_v_o=0, pred_hit_o=0, pred_jump_o=0; other outputs hold their last value.
- No bypass: a lookup in the same cycle as an update sees table state from before the update. The update becomes visible to lookups issued in the next cycle.
- Insert (upd_v_i & upd_insert_i):
  - If a valid entry already has tag upd_pc_i[31:1], rewrite that entry: tgt=upd_tgt_i, cnt=BHT_INIT. No duplicate entries ever exist.
  - Otherwise the victim is the lowest-index invalid entry. If all entries are valid, the victim is the entry at the replacement pointer, and the pointer then increments, wrapping from ENTRIES-1 to 0.
  - The victim is written with valid=1, tag, tgt, cnt=BHT_INIT.
  - Filling an invalid entry does not move the pointer.
- BHT train (upd_v_i & upd_bht_i & !upd_insert_i):
  - Applies to upd_entry_i with no tag check.
  - Saturating: inc at 11 stays 11; dec at 00 stays 00.
  - The entry stays valid at 00.
  - Ignored if the entry is invalid.
- Target update (upd_v_i & upd_tgt_en_i & !upd_insert_i): tgt[upd_entry_i]=upd_tgt_i if that entry is valid. It may combine with a BHT train in the same cycle.
- When insert is set, the bht and tgt_en fields are ignored.
- flush_i:
  - Clears all valid bits at the next posedge; the pointer is reset to 0.
  - Flush beats an update in the same cycle; the update is dropped.
  - A lookup in the flush cycle uses pre-flush state. Lookups in later cycles miss.
- Fields with upd_v_i=0 are don't-care.
- Single update per cycle; no backpressure; no ready signal.

Test Plan:
1. Reset, then lookup 0x100 -> pred_v_o=1, hit=0, jump=0, entry=0 one cycle later.
2. Insert pc=0x100 tgt=0x200, then lookup 0x100 -> hit=1, jump=1, tgt=0x200, entry=0. Lookup 0x104 -> hit=0.
3. Counter walk on entry 0:
   - dec -> cnt=01, jump=0.
   - dec -> 00.
   - dec -> stays 00, hit still 1.
   - inc x3 -> 11.
   - inc -> stays 11, jump=1.
4. Replacement with ENTRIES=8:
   - Insert pcs 0x000..0x01C (step 4) -> entries 0..7.
   - Insert 0x020 -> replaces entry 0; lookup 0x000 misses.
   - Insert 0x024 -> replaces entry 1.
   - Re-insert 0x020 with tgt 0x400 -> entry 0 rewritten, pointer unchanged.
5. Same-cycle lookup 0x300 with insert 0x300 -> miss. Lookup in the next cycle -> hit.
6. flush_i with upd_v_i insert 0x500 in the same cycle -> all later lookups miss, 0x500 absent. rst=1 asserted mid-stream -> all outputs 0 next cycle.

Source files
------------

// File: rtl/n2_btb_if.sv
// Fetch-lookup, prediction and execute-update signals of the branch target buffer.
// The master side is the fetch/execute pair; the slave side is the BTB itself.
interface n2_btb_if #(
  parameter int ENTRY_W = 3
);
  logic               lookup_v_i;
  logic [31:0]        lookup_pc_i;

  logic               pred_v_o;
  logic               pred_hit_o;
  logic               pred_jump_o;
  logic [31:0]        pred_tgt_o;
  logic [31:0]        pred_pc_o;
  logic [ENTRY_W-1:0] pred_entry_o;

  logic               upd_v_i;
  logic               upd_insert_i;
  logic               upd_bht_i;
  logic               upd_inc_i;
  logic               upd_tgt_en_i;
  logic [31:0]        upd_pc_i;
  logic [31:0]        upd_tgt_i;
  logic [ENTRY_W-1:0] upd_entry_i;

  modport master (
    output lookup_v_i, lookup_pc_i,
    output upd_v_i, upd_insert_i, upd_bht_i, upd_inc_i, upd_tgt_en_i,
    output upd_pc_i, upd_tgt_i, upd_entry_i,
    input  pred_v_o, pred_hit_o, pred_jump_o, pred_tgt_o, pred_pc_o, pred_entry_o
  );

  modport slave (
    input  lookup_v_i, lookup_pc_i,
    input  upd_v_i, upd_insert_i, upd_bht_i, upd_inc_i, upd_tgt_en_i,
    input  upd_pc_i, upd_tgt_i, upd_entry_i,
    output pred_v_o, pred_hit_o, pred_jump_o, pred_tgt_o, pred_pc_o, pred_entry_o
  );
endinterface

// File: rtl/n2_btb.sv
// Fully associative branch target buffer with a 2-bit saturating counter per entry.
// Prediction is registered one cycle after the lookup; updates become visible the cycle after.
module n2_btb #(
  parameter int         ENTRIES  = 8,
  parameter int         ENTRY_W  = $clog2(ENTRIES),
  parameter logic [1:0] BHT_INIT = 2'b10
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    flush_i,
  n2_btb_if.slave btb
);

  logic [ENTRIES-1:0] valid;
  logic [30:0]        tag [ENTRIES];
  logic [31:0]        tgt [ENTRIES];
  logic [1:0]         cnt [ENTRIES];
  logic [ENTRY_W-1:0] rep_ptr;

  logic               lk_hit;
  logic [ENTRY_W-1:0] lk_idx;
  logic               ins_match;
  logic [ENTRY_W-1:0] ins_idx;
  logic               free_found;
  logic [ENTRY_W-1:0] free_idx;
  logic [ENTRY_W-1:0] victim;
  logic [1:0]         cnt_cur;
  logic [1:0]         cnt_nxt;
  logic               do_insert;
  logic               do_modify;

  // NOTE: every always_comb output gets a default before the loops, so no path leaves a latch.
  always_comb begin
    lk_hit     = 1'b0;
    lk_idx     = '0;
    ins_match  = 1'b0;
    ins_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid[i] && tag[i] == btb.lookup_pc_i[31:1]) begin
        lk_hit = 1'b1;
        lk_idx = ENTRY_W'(i);
      end
      if (valid[i] && tag[i] == btb.upd_pc_i[31:1]) begin
        ins_match = 1'b1;
        ins_idx   = ENTRY_W'(i);
      end
    end
    // Descending scan so the lowest-index free slot is the one that survives.
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        free_found = 1'b1;
        free_idx   = ENTRY_W'(i);
      end
    end
  end

  always_comb begin
    if (ins_match)       victim = ins_idx;
    else if (free_found) victim = free_idx;
    else                 victim = rep_ptr;

    cnt_cur = cnt[btb.upd_entry_i];
    if (btb.upd_inc_i) cnt_nxt = (cnt_cur == 2'b11) ? 2'b11 : cnt_cur + 2'b01;
    else               cnt_nxt = (cnt_cur == 2'b00) ? 2'b00 : cnt_cur - 2'b01;

    do_insert = !rst && !flush_i && btb.upd_v_i && btb.upd_insert_i;
    do_modify = !rst && !flush_i && btb.upd_v_i && !btb.upd_insert_i && valid[btb.upd_entry_i];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid             <= '0;
      rep_ptr           <= '0;
      for (int i = 0; i < ENTRIES; i++) cnt[i] <= 2'b00;
      btb.pred_v_o      <= 1'b0;
      btb.pred_hit_o    <= 1'b0;
      btb.pred_jump_o   <= 1'b0;
      btb.pred_tgt_o    <= '0;
      btb.pred_pc_o     <= '0;
      btb.pred_entry_o  <= '0;
    end else begin
      if (btb.lookup_v_i) begin
        btb.pred_v_o     <= 1'b1;
        btb.pred_hit_o   <= lk_hit;
        btb.pred_jump_o  <= lk_hit & cnt[lk_idx][1];
        btb.pred_tgt_o   <= lk_hit ? tgt[lk_idx] : 32'h0;
        btb.pred_entry_o <= lk_hit ? lk_idx : '0;
        btb.pred_pc_o    <= btb.lookup_pc_i;
      end else begin
        btb.pred_v_o    <= 1'b0;
        btb.pred_hit_o  <= 1'b0;
        btb.pred_jump_o <= 1'b0;
      end

      if (flush_i) begin
        valid   <= '0;
        rep_ptr <= '0;
      end else if (do_insert) begin
        valid[victim] <= 1'b1;
        cnt[victim]   <= BHT_INIT;
        if (!ins_match && !free_found) rep_ptr <= rep_ptr + 1'b1;
      end else if (do_modify && btb.upd_bht_i) begin
        cnt[btb.upd_entry_i] <= cnt_nxt;
      end
    end
  end

  // NOTE: tag/target storage is deliberately not reset; a cleared valid bit makes its contents unused.
  always_ff @(posedge clk) begin
    if (do_insert) begin
      tag[victim] <= btb.upd_pc_i[31:1];
      tgt[victim] <= btb.upd_tgt_i;
    end else if (do_modify && btb.upd_tgt_en_i) begin
      tgt[btb.upd_entry_i] <= btb.upd_tgt_i;
    end
  end

endmodule

// File: tb/tb_n2_btb.sv
// Directed bench for n2_btb: a per-cycle vector table for lookup/train/target paths,
// then hand sequences for replacement, same-cycle visibility, flush and mid-stream reset.
module tb_n2_btb;

  localparam int ENTRIES = 8;
  localparam int EW      = 3;

  logic clk = 1'b0;
  logic rst;
  logic flush_i;

  n2_btb_if #(.ENTRY_W(EW)) bus ();

  n2_btb #(.ENTRIES(ENTRIES), .ENTRY_W(EW), .BHT_INIT(2'b10)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush_i),
    .btb     (bus)
  );

  always #5 clk = ~clk;

  int n_total  = 0;
  int n_passed = 0;

  typedef struct {
    string          name;
    logic           upd_v, ins, bht, inc, tgt_en;
    logic [31:0]    upc, utgt;
    logic [EW-1:0]  uent;
    logic           lk_v;
    logic [31:0]    lpc;
    logic           e_hit, e_jump;
    logic [31:0]    e_tgt;
    logic [EW-1:0]  e_entry;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic uv, logic ins, logic bht, logic inc, logic te,
                              logic [31:0] upc, logic [31:0] utgt, logic [EW-1:0] uent,
                              logic lv, logic [31:0] lpc, logic eh, logic ej,
                              logic [31:0] et, logic [EW-1:0] ee);
    vec_t v;
    v.name = n; v.upd_v = uv; v.ins = ins; v.bht = bht; v.inc = inc; v.tgt_en = te;
    v.upc = upc; v.utgt = utgt; v.uent = uent; v.lk_v = lv; v.lpc = lpc;
    v.e_hit = eh; v.e_jump = ej; v.e_tgt = et; v.e_entry = ee;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush_i          = 1'b0;
    bus.lookup_v_i   = 1'b0;
    bus.lookup_pc_i  = '0;
    bus.upd_v_i      = 1'b0;
    bus.upd_insert_i = 1'b0;
    bus.upd_bht_i    = 1'b0;
    bus.upd_inc_i    = 1'b0;
    bus.upd_tgt_en_i = 1'b0;
    bus.upd_pc_i     = '0;
    bus.upd_tgt_i    = '0;
    bus.upd_entry_i  = '0;
  endtask

  task automatic chk_pred(string n, logic [31:0] pc, logic eh, logic ej,
                          logic [31:0] et, logic [EW-1:0] ee);
    check({n, ".v"},     32'(bus.pred_v_o),     32'd1);
    check({n, ".hit"},   32'(bus.pred_hit_o),   32'(eh));
    check({n, ".jump"},  32'(bus.pred_jump_o),  32'(ej));
    check({n, ".tgt"},   bus.pred_tgt_o,        et);
    check({n, ".entry"}, 32'(bus.pred_entry_o), 32'(ee));
    check({n, ".pc"},    bus.pred_pc_o,         pc);
  endtask

  task automatic insert(logic [31:0] pc, logic [31:0] t);
    idle();
    bus.upd_v_i = 1'b1; bus.upd_insert_i = 1'b1; bus.upd_pc_i = pc; bus.upd_tgt_i = t;
    tick();
    idle();
  endtask

  task automatic train(logic [EW-1:0] e, logic inc);
    idle();
    bus.upd_v_i = 1'b1; bus.upd_bht_i = 1'b1; bus.upd_inc_i = inc; bus.upd_entry_i = e;
    tick();
    idle();
  endtask

  task automatic look(string n, logic [31:0] pc, logic eh, logic ej,
                      logic [31:0] et, logic [EW-1:0] ee);
    idle();
    bus.lookup_v_i = 1'b1; bus.lookup_pc_i = pc;
    tick();
    idle();
    chk_pred(n, pc, eh, ej, et, ee);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick();
    tick();
    check("rst.v",     32'(bus.pred_v_o),     32'd0);
    check("rst.hit",   32'(bus.pred_hit_o),   32'd0);
    check("rst.jump",  32'(bus.pred_jump_o),  32'd0);
    check("rst.tgt",   bus.pred_tgt_o,        32'd0);
    check("rst.entry", 32'(bus.pred_entry_o), 32'd0);
    rst = 1'b0;

    // Each row is one cycle; a same-cycle lookup sees the table before that row's update.
    //                  name     uv ins bht inc te  upc       utgt      ent lv lpc       hit jmp tgt       entry
    vecs.push_back(mk("miss0",   0, 0,  0,  0,  0, 32'h0,    32'h0,    0,  1, 32'h100, 0,  0,  32'h0,    0));
    vecs.push_back(mk("ins100",  1, 1,  0,  0,  0, 32'h100,  32'h200,  0,  0, 32'h0,   0,  0,  32'h0,    0));
    vecs.push_back(mk("hit100",  0, 0,  0,  0,  0, 32'h0,    32'h0,    0,  1, 32'h100, 1,  1,  32'h200,  0));
    vecs.push_back(mk("miss104", 0, 0,  0,  0,  0, 32'h0,    32'h0,    0,  1, 32'h104, 0,  0,  32'h0,    0));
    vecs.push_back(mk("dec1",    1, 0,  1,  0,  0, 32'h0,    32'h0,    0,  1, 32'h100, 1,  1,  32'h200,  0));
    vecs.push_back(mk("dec2",    1, 0,  1,  0,  0, 32'h0,    32'h0,    0,  1, 32'h100, 1,  0,  32'h200,  0));
    vecs.push_back(mk("dec3",    1, 0,  1,  0,  0, 32'h0,    32'h0,    0,  1, 32'h100, 1,  0,  32'h200,  0));
    vecs.push_back(mk("inc1",    1, 0,  1,  1,  0, 32'h0,    32'h0,    0,  1, 32'h100, 1,  0,  32'h200,  0));
    vecs.push_back(mk("inc2",    1, 0,  1,  1,  0, 32'h0,    32'h0,    0,  1, 32'h100, 1,  0,  32'h200,  0));
    vecs.push_back(mk("inc3",    1, 0,  1,  1,  0, 32'h0,    32'h0,    0,  1, 32'h100, 1,  1,  32'h200,  0));
    vecs.push_back(mk("inc4",    1, 0,  1,  1,  0, 32'h0,    32'h0,    0,  1, 32'h100, 1,  1,  32'h200,  0));
    vecs.push_back(mk("dec_sat", 1, 0,  1,  0,  0, 32'h0,    32'h0,    0,  1, 32'h100, 1,  1,  32'h200,  0));
    vecs.push_back(mk("dec_10",  1, 0,  1,  0,  0, 32'h0,    32'h0,    0,  1, 32'h100, 1,  1,  32'h200,  0));
    vecs.push_back(mk("at01",    0, 0,  0,  0,  0, 32'h0,    32'h0,    0,  1, 32'h100, 1,  0,  32'h200,  0));
    vecs.push_back(mk("tgt_bht", 1, 0,  1,  1,  1, 32'h0,    32'h280,  0,  1, 32'h100, 1,  0,  32'h200,  0));
    vecs.push_back(mk("new_tgt", 0, 0,  0,  0,  0, 32'h0,    32'h0,    0,  1, 32'h100, 1,  1,  32'h280,  0));
    vecs.push_back(mk("tgt_inv", 1, 0,  1,  1,  1, 32'h0,    32'h999,  5,  1, 32'h100, 1,  1,  32'h280,  0));
    vecs.push_back(mk("reins",   1, 1,  1,  0,  1, 32'h100,  32'h300,  0,  1, 32'h100, 1,  1,  32'h280,  0));
    vecs.push_back(mk("rewrote", 0, 0,  0,  0,  0, 32'h0,    32'h0,    0,  1, 32'h100, 1,  1,  32'h300,  0));
    vecs.push_back(mk("ins108",  1, 1,  0,  0,  0, 32'h108,  32'h308,  0,  0, 32'h0,   0,  0,  32'h0,    0));
    vecs.push_back(mk("hit108",  0, 0,  0,  0,  0, 32'h0,    32'h0,    0,  1, 32'h108, 1,  1,  32'h308,  1));

    foreach (vecs[k]) begin
      idle();
      bus.upd_v_i      = vecs[k].upd_v;
      bus.upd_insert_i = vecs[k].ins;
      bus.upd_bht_i    = vecs[k].bht;
      bus.upd_inc_i    = vecs[k].inc;
      bus.upd_tgt_en_i = vecs[k].tgt_en;
      bus.upd_pc_i     = vecs[k].upc;
      bus.upd_tgt_i    = vecs[k].utgt;
      bus.upd_entry_i  = vecs[k].uent;
      bus.lookup_v_i   = vecs[k].lk_v;
      bus.lookup_pc_i  = vecs[k].lpc;
      tick();
      idle();
      if (vecs[k].lk_v) begin
        chk_pred(vecs[k].name, vecs[k].lpc, vecs[k].e_hit, vecs[k].e_jump,
                 vecs[k].e_tgt, vecs[k].e_entry);
      end else begin
        check({vecs[k].name, ".v"},   32'(bus.pred_v_o),   32'd0);
        check({vecs[k].name, ".hit"}, 32'(bus.pred_hit_o), 32'd0);
      end
    end

    // Flush cycle lookup still sees the old table; afterwards everything misses.
    idle();
    flush_i = 1'b1; bus.lookup_v_i = 1'b1; bus.lookup_pc_i = 32'h108;
    tick();
    idle();
    chk_pred("flush_cyc", 32'h108, 1, 1, 32'h308, 1);
    look("post_flush", 32'h100, 0, 0, 32'h0, 0);

    // Fill all eight entries, then exercise round-robin replacement.
    for (int i = 0; i < ENTRIES; i++) insert(32'(i * 4), 32'h1000 + 32'(i * 4));
    for (int i = 0; i < ENTRIES; i++) look($sformatf("fill%0d", i), 32'(i * 4), 1, 1, 32'h1000 + 32'(i * 4), EW'(i));
    insert(32'h020, 32'h2020);
    look("evict0_old", 32'h000, 0, 0, 32'h0, 0);
    look("evict0_new", 32'h020, 1, 1, 32'h2020, 0);
    insert(32'h024, 32'h2024);
    look("evict1_new", 32'h024, 1, 1, 32'h2024, 1);
    train(0, 1'b0);
    train(0, 1'b0);
    look("e0_cnt00", 32'h020, 1, 0, 32'h2020, 0);
    insert(32'h020, 32'h400);
    look("reins020", 32'h020, 1, 1, 32'h400, 0);
    insert(32'h028, 32'h2028);
    look("evict2_new", 32'h028, 1, 1, 32'h2028, 2);
    look("evict2_old", 32'h008, 0, 0, 32'h0, 0);

    // Same-cycle insert is invisible to the lookup; the next cycle sees it.
    idle();
    bus.upd_v_i = 1'b1; bus.upd_insert_i = 1'b1; bus.upd_pc_i = 32'h300; bus.upd_tgt_i = 32'h3300;
    bus.lookup_v_i = 1'b1; bus.lookup_pc_i = 32'h300;
    tick();
    idle();
    chk_pred("same_cyc", 32'h300, 0, 0, 32'h0, 0);
    look("next_cyc", 32'h300, 1, 1, 32'h3300, 3);

    // Flush beats a same-cycle insert.
    idle();
    flush_i = 1'b1; bus.upd_v_i = 1'b1; bus.upd_insert_i = 1'b1;
    bus.upd_pc_i = 32'h500; bus.upd_tgt_i = 32'h5500;
    bus.lookup_v_i = 1'b1; bus.lookup_pc_i = 32'h300;
    tick();
    idle();
    chk_pred("flush2_cyc", 32'h300, 1, 1, 32'h3300, 3);
    look("flush_500", 32'h500, 0, 0, 32'h0, 0);
    look("flush_300", 32'h300, 0, 0, 32'h0, 0);
    insert(32'h600, 32'h3600);
    look("ins600", 32'h600, 1, 1, 32'h3600, 0);

    // Idle cycle: valid/hit/jump drop, the rest holds.
    tick();
    check("hold.v",     32'(bus.pred_v_o),     32'd0);
    check("hold.hit",   32'(bus.pred_hit_o),   32'd0);
    check("hold.jump",  32'(bus.pred_jump_o),  32'd0);
    check("hold.tgt",   bus.pred_tgt_o,        32'h3600);
    check("hold.pc",    bus.pred_pc_o,         32'h600);

    // Mid-stream reset drops the concurrent lookup and insert.
    idle();
    rst = 1'b1;
    bus.lookup_v_i = 1'b1; bus.lookup_pc_i = 32'h600;
    bus.upd_v_i = 1'b1; bus.upd_insert_i = 1'b1; bus.upd_pc_i = 32'h700; bus.upd_tgt_i = 32'h3700;
    tick();
    idle();
    rst = 1'b0;
    check("mrst.v",     32'(bus.pred_v_o),     32'd0);
    check("mrst.hit",   32'(bus.pred_hit_o),   32'd0);
    check("mrst.jump",  32'(bus.pred_jump_o),  32'd0);
    check("mrst.tgt",   bus.pred_tgt_o,        32'd0);
    check("mrst.pc",    bus.pred_pc_o,         32'd0);
    check("mrst.entry", 32'(bus.pred_entry_o), 32'd0);
    look("mrst_600", 32'h600, 0, 0, 32'h0, 0);
    look("mrst_700", 32'h700, 0, 0, 32'h0, 0);

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
